// File: rtl/async_arb_pkg.sv
// Shared types and defaults for the async request arbiter.
// Latency: none (declarations only).
// Backpressure: n/a.
package async_arb_pkg;

  localparam int DEF_NUM_REQ   = 4;
  localparam int DEF_DB_CYCLES = 4;
  localparam int DEF_ID_W      = $clog2(DEF_NUM_REQ);

  typedef enum logic {
    IDLE  = 1'b0,
    OFFER = 1'b1
  } arb_state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit above last_grant, wrapping.
// Latency: combinational.
// Backpressure: none.
// Ports: pend (request vector), last_grant -> found, id.
module rr_pick #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = 2
) (
  input  logic [NUM_REQ-1:0] pend,
  input  logic [ID_W-1:0]    last_grant,
  output logic               found,
  output logic [ID_W-1:0]    id
);

  // Pass 1 finds the lowest set bit overall (the wrap-around choice); pass 2
  // overrides it with the lowest set bit strictly above last_grant, if any.
  // Descending loops make the last write the lowest index.
  always_comb begin
    found = |pend;
    id    = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i]) id = ID_W'(i);
    end
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (pend[i] && (i > int'(last_grant))) id = ID_W'(i);
    end
  end

endmodule

// File: rtl/sync_high.sv
// Two-flop synchronizer whose flops reset to 1 (idle-high lines).
// Latency: 2 clk edges from input sample to sync_out.
// Backpressure: none.
// Ports: clk, n_rst (async active-low), async_in -> sync_out.
module sync_high (
  input  logic clk,
  input  logic n_rst,
  input  logic async_in,
  output logic sync_out
);

  logic meta;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      meta     <= 1'b1;
      sync_out <= 1'b1;
    end else begin
      meta     <= async_in;
      sync_out <= meta;
    end
  end

endmodule

// File: rtl/async_req_arbiter.sv
// Collects async active-low request edges into pending flags, offers them round-robin.
// Latency: async low sampled at edge k -> pending after k+2 -> evt_valid after k+3.
// Backpressure: evt_id held until evt_ready; new edges on a pending channel set overflow.
// Ports: clk, n_rst, async_req_n[NUM_REQ], evt_valid/evt_id/evt_ready handshake,
//        pending[NUM_REQ], overflow[NUM_REQ] (sticky), clear_ovf.
// Build option: SYNC_DEBOUNCE_EN adds a DB_CYCLES stability filter after the synchronizer.
module async_req_arbiter
  import async_arb_pkg::*;
#(
  parameter int NUM_REQ   = DEF_NUM_REQ,
  parameter int DB_CYCLES = DEF_DB_CYCLES
) (
  input  logic                       clk,
  input  logic                       n_rst,
  input  logic [NUM_REQ-1:0]         async_req_n,
  output logic                       evt_valid,
  output logic [$clog2(NUM_REQ)-1:0] evt_id,
  input  logic                       evt_ready,
  output logic [NUM_REQ-1:0]         pending,
  output logic [NUM_REQ-1:0]         overflow,
  input  logic                       clear_ovf
);

  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0] sync2;
  logic [NUM_REQ-1:0] level;
  logic [NUM_REQ-1:0] hist;
  logic [NUM_REQ-1:0] fall;
  logic [NUM_REQ-1:0] acc_vec;
  logic [NUM_REQ-1:0] pend_q;
  logic [NUM_REQ-1:0] ovf_q;

  arb_state_t      state_q, state_d;
  logic [ID_W-1:0] id_q, id_d;
  logic [ID_W-1:0] last_q, last_d;
  logic            pick_found;
  logic [ID_W-1:0] pick_id;
  logic            accept;

  genvar g;
  for (g = 0; g < NUM_REQ; g++) begin : g_sync
    sync_high u_sync (
      .clk      (clk),
      .n_rst    (n_rst),
      .async_in (async_req_n[g]),
      .sync_out (sync2[g])
    );
  end

`ifdef SYNC_DEBOUNCE_EN
  localparam int CNT_W = $clog2(DB_CYCLES + 1);

  // The filtered level only follows sync2 after DB_CYCLES consecutive
  // mismatching cycles; any agreeing cycle restarts the count.
  for (g = 0; g < NUM_REQ; g++) begin : g_db
    logic [CNT_W-1:0] cnt;
    logic             filt;

    always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
        cnt  <= '0;
        filt <= 1'b1;
      end else if (sync2[g] == filt) begin
        cnt <= '0;
      end else if (cnt == CNT_W'(DB_CYCLES - 1)) begin
        filt <= sync2[g];
        cnt  <= '0;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end

    assign level[g] = filt;
  end
`else
  assign level = sync2;
`endif

  // hist resets high, so a line held low through reset yields one event.
  assign fall   = hist & ~level;
  assign accept = evt_valid & evt_ready;

  always_comb begin
    acc_vec = '0;
    if (accept) acc_vec[evt_id] = 1'b1;
  end

  rr_pick #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_pick (
    .pend       (pend_q),
    .last_grant (last_q),
    .found      (pick_found),
    .id         (pick_id)
  );

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q <= IDLE;
      id_q    <= '0;
      last_q  <= ID_W'(NUM_REQ - 1);
    end else begin
      state_q <= state_d;
      id_q    <= id_d;
      last_q  <= last_d;
    end
  end

  always_comb begin
    state_d = state_q;
    id_d    = id_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        if (pick_found) begin
          id_d    = pick_id;
          state_d = OFFER;
        end
      end
      OFFER: begin
        if (evt_ready) begin
          last_d  = id_q;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // A fall on the channel being accepted re-arms pending instead of
  // counting as lost; overflow set takes priority over clear_ovf.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      hist   <= '1;
      pend_q <= '0;
      ovf_q  <= '0;
    end else begin
      hist   <= level;
      pend_q <= (pend_q & ~acc_vec) | fall;
      ovf_q  <= (clear_ovf ? '0 : ovf_q) | (fall & pend_q & ~acc_vec);
    end
  end

  assign evt_valid = (state_q == OFFER);
  assign evt_id    = id_q;
  assign pending   = pend_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_async_req_arbiter.sv
// Bench for async_req_arbiter: directed scenarios plus random traffic against a reference model.
// Latency: n/a.
// Backpressure: evt_ready driven randomly and by scenario.
module tb_async_req_arbiter;

  localparam int N  = 4;
  localparam int DB = 4;
  localparam int IW = 2;
`ifdef SYNC_DEBOUNCE_EN
  localparam int GLITCH_EVENTS = 0;
`else
  localparam int GLITCH_EVENTS = 1;
`endif

  logic          clk = 1'b0;
  logic          n_rst = 1'b0;
  logic [N-1:0]  async_req_n = '1;
  logic          evt_ready = 1'b0;
  logic          clear_ovf = 1'b0;
  logic          evt_valid;
  logic [IW-1:0] evt_id;
  logic [N-1:0]  pending;
  logic [N-1:0]  overflow;

  async_req_arbiter #(.NUM_REQ(N), .DB_CYCLES(DB)) dut (
    .clk         (clk),
    .n_rst       (n_rst),
    .async_req_n (async_req_n),
    .evt_valid   (evt_valid),
    .evt_id      (evt_id),
    .evt_ready   (evt_ready),
    .pending     (pending),
    .overflow    (overflow),
    .clear_ovf   (clear_ovf)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int accepts = 0;
  int cyc = 0;
  int exp_q[$];
  int got_q[$];
  int got_cyc[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: actual=%0h required=%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Event-level view: the line level seen by the arbiter is the input as
  // sampled two edges earlier (optionally filtered); each high->low change
  // of that level is one event. Offers follow round-robin from last grant.
  logic [N-1:0] m_samp, m_raw, m_filt, m_prev, m_pend, m_ovf;
  int  m_run[N];
  bit  m_valid;
  int  m_id, m_last;

  function automatic void m_reset();
    m_samp = '1; m_raw = '1; m_filt = '1; m_prev = '1;
    m_pend = '0; m_ovf = '0;
    for (int i = 0; i < N; i++) m_run[i] = 0;
    m_valid = 1'b0; m_id = 0; m_last = N - 1;
    exp_q.delete();
  endfunction

  function automatic void m_step();
    logic [N-1:0] lvl, fall, accv, pend_old;
    bit took;
`ifdef SYNC_DEBOUNCE_EN
    lvl = m_filt;
`else
    lvl = m_raw;
`endif
    fall = m_prev & ~lvl;
    accv = '0;
    if (m_valid && evt_ready) accv[m_id] = 1'b1;
    m_ovf = (clear_ovf ? '0 : m_ovf) | (fall & m_pend & ~accv);
    pend_old = m_pend;
    m_pend = (m_pend & ~accv) | fall;
    if (m_valid && evt_ready) begin
      m_last  = m_id;
      m_valid = 1'b0;
    end else if (!m_valid && pend_old != '0) begin
      took = 1'b0;
      for (int k = 1; k <= N; k++) begin
        int c;
        c = (m_last + k) % N;
        if (!took && pend_old[c]) begin
          took = 1'b1;
          m_id = c;
        end
      end
      m_valid = 1'b1;
      exp_q.push_back(m_id);
    end
    m_prev = lvl;
    for (int i = 0; i < N; i++) begin
      if (m_raw[i] != m_filt[i]) begin
        m_run[i]++;
        if (m_run[i] == DB) begin
          m_filt[i] = m_raw[i];
          m_run[i]  = 0;
        end
      end else begin
        m_run[i] = 0;
      end
    end
    m_raw  = m_samp;
    m_samp = async_req_n;
  endfunction

  always @(posedge clk or negedge n_rst) begin
    if (!n_rst) m_reset();
    else        m_step();
  end

  always @(posedge clk) cyc++;

  // ---------------- monitor / scoreboard ----------------
  always @(negedge clk) begin
    check("evt_valid", 32'(evt_valid), 32'(m_valid));
    if (m_valid) check("evt_id", 32'(evt_id), 32'(m_id));
    check("pending", 32'(pending), 32'(m_pend));
    check("overflow", 32'(overflow), 32'(m_ovf));
    if (evt_valid === 1'b1 && evt_ready) begin
      accepts++;
      got_q.push_back(int'(evt_id));
      got_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        check("grant_unexpected", 32'(evt_id), 32'hFFFF_FFFF);
      end else begin
        check("grant_order", 32'(evt_id), 32'(exp_q.pop_front()));
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    n_rst = 1'b0;
    tick(2);
    n_rst = 1'b1;
    tick(2);
  endtask

  task automatic wait_offer(input int ch);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 30 && !ok; i++) begin
      @(negedge clk);
      if (evt_valid === 1'b1 && int'(evt_id) == ch) ok = 1'b1;
    end
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL wait_offer: actual=no offer of ch%0d in 30 cycles required=offer", ch);
    end
  endtask

  int a0, nv;

  initial begin
    m_reset();
    tick(3);
    @(negedge clk);
    check("reset_valid", 32'(evt_valid), 32'd0);
    check("reset_pending", 32'(pending), 32'd0);
    check("reset_overflow", 32'(overflow), 32'd0);
    n_rst = 1'b1;
    tick(3);

    // 1: single event latency
    evt_ready = 1'b1;
    async_req_n[2] = 1'b0;
    tick(3);
    async_req_n[2] = 1'b1;
    @(negedge clk);
    check("t1_pending_edge3", 32'(pending[2]), 32'd1);
    check("t1_valid_edge3", 32'(evt_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t1_valid_edge4", 32'(evt_valid), 32'd1);
    check("t1_id_edge4", 32'(evt_id), 32'd2);
    tick();
    @(negedge clk);
    check("t1_valid_after", 32'(evt_valid), 32'd0);
    check("t1_pending_after", 32'(pending[2]), 32'd0);

    // 2: simultaneous events, round-robin order and spacing
    do_reset();
    got_q.delete(); got_cyc.delete();
    async_req_n = 4'b0100;
    tick(3);
    async_req_n = '1;
    tick(12);
    check("t2_count", 32'(got_q.size()), 32'd3);
    if (got_q.size() == 3) begin
      check("t2_g0", 32'(got_q[0]), 32'd0);
      check("t2_g1", 32'(got_q[1]), 32'd1);
      check("t2_g2", 32'(got_q[2]), 32'd3);
      check("t2_space01", 32'(got_cyc[1] - got_cyc[0]), 32'd2);
      check("t2_space12", 32'(got_cyc[2] - got_cyc[1]), 32'd2);
    end
    got_q.delete(); got_cyc.delete();
    async_req_n = 4'b0110;
    tick(3);
    async_req_n = '1;
    tick(10);
    check("t2_wrap_count", 32'(got_q.size()), 32'd2);
    if (got_q.size() == 2) begin
      check("t2_wrap_g0", 32'(got_q[0]), 32'd0);
      check("t2_wrap_g1", 32'(got_q[1]), 32'd3);
    end

    // 3: backpressure stability, overflow, clear
    do_reset();
    evt_ready = 1'b0;
    async_req_n[1] = 1'b0;
    wait_offer(1);
    tick();
    async_req_n[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      tick();
      @(negedge clk);
      check("t3_hold_valid", 32'(evt_valid), 32'd1);
      check("t3_hold_id", 32'(evt_id), 32'd1);
    end
    tick();
    async_req_n[1] = 1'b0;
    tick(3);
    @(negedge clk);
    check("t3_overflow_set", 32'(overflow), 32'b0010);
    tick();
    clear_ovf = 1'b1;
    tick();
    clear_ovf = 1'b0;
    @(negedge clk);
    check("t3_overflow_clr", 32'(overflow), 32'd0);
    async_req_n[1] = 1'b1;
    evt_ready = 1'b1;
    tick(6);

    // 4: new fall in the accept cycle of the same channel
    do_reset();
    evt_ready = 1'b0;
    async_req_n[0] = 1'b0;
    wait_offer(0);
    tick();
    async_req_n[0] = 1'b1;
    tick(5);
    async_req_n[0] = 1'b0;
    tick(2);
    evt_ready = 1'b1;
    tick();
    evt_ready = 1'b0;
    @(negedge clk);
    check("t4_pending_kept", 32'(pending[0]), 32'd1);
    check("t4_no_overflow", 32'(overflow[0]), 32'd0);
    check("t4_valid_gap", 32'(evt_valid), 32'd0);
    tick();
    @(negedge clk);
    check("t4_reoffer_valid", 32'(evt_valid), 32'd1);
    check("t4_reoffer_id", 32'(evt_id), 32'd0);
    async_req_n[0] = 1'b1;
    evt_ready = 1'b1;
    tick(6);

    // 5: reset during an offer
    do_reset();
    evt_ready = 1'b0;
    async_req_n[2] = 1'b0;
    wait_offer(2);
    tick();
    n_rst = 1'b0;
    #1;
    check("t5_async_valid", 32'(evt_valid), 32'd0);
    check("t5_async_pending", 32'(pending), 32'd0);
    async_req_n = '1;
    tick(2);
    n_rst = 1'b1;
    evt_ready = 1'b1;
    nv = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (evt_valid !== 1'b0) nv++;
    end
    check("t5_no_events", 32'(nv), 32'd0);

    // held low through reset -> exactly one event
    async_req_n[3] = 1'b0;
    n_rst = 1'b0;
    tick(2);
    a0 = accepts;
    n_rst = 1'b1;
    tick(12);
    check("t5_held_low_one", 32'(accepts - a0), 32'd1);
    async_req_n[3] = 1'b1;
    tick(10);

    // 6: short glitch and long pulse
    do_reset();
    evt_ready = 1'b1;
    a0 = accepts;
    async_req_n[1] = 1'b0;
    tick(2);
    async_req_n[1] = 1'b1;
    tick(15);
    check("t6_glitch", 32'(accepts - a0), 32'(GLITCH_EVENTS));
    a0 = accepts;
    async_req_n[1] = 1'b0;
    tick(6);
    async_req_n[1] = 1'b1;
    tick(20);
    check("t6_long_pulse", 32'(accepts - a0), 32'd1);

    // random traffic
    do_reset();
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 7) == 0) async_req_n[i] = ~async_req_n[i];
      end
      evt_ready = ($urandom_range(0, 1) == 1);
      clear_ovf = ($urandom_range(0, 31) == 0);
      if ($urandom_range(0, 499) == 0) do_reset();
      else tick();
    end
    clear_ovf = 1'b0;
    async_req_n = '1;
    evt_ready = 1'b1;
    tick(30);
    check("drain_queue_empty", 32'(exp_q.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
